// File: rtl/axi_mem_slave_pkg.sv
// Shared AXI widths, response/burst encodings, FSM states and the
// per-beat address helpers for the axi_mem_slave responder.
package axi_mem_slave_pkg;

  localparam int AXI_ADDR_WIDTH = 64;
  localparam int AXI_DATA_WIDTH = 64;
  localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;
  localparam int AXI_ID_WIDTH   = 4;
  localparam int AXI_USER_WIDTH = 1;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  typedef enum logic       {R_IDLE, R_DATA}         rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;

  // Latched AR/AW request; addr tracks the beat currently being serviced.
  typedef struct packed {
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [AXI_ID_WIDTH-1:0]   id;
    logic [7:0]                len;
    logic [1:0]                size;
    logic [1:0]                burst;
  } ax_req_t;

  function automatic logic [1:0] clamp_size(input logic [2:0] size);
    return (size > 3'd3) ? 2'd3 : size[1:0];
  endfunction

  // WRAP is serviced as INCR.
  function automatic logic [AXI_ADDR_WIDTH-1:0] next_addr(
    input logic [AXI_ADDR_WIDTH-1:0] addr,
    input logic [1:0]                size,
    input logic [1:0]                burst
  );
    return (burst == AXI_BURST_FIXED) ? addr : addr + (AXI_ADDR_WIDTH'(1) << size);
  endfunction

endpackage

// File: rtl/axi_mem_slave_if.sv
// AXI4 link between the core's master and the axi_mem_slave responder.
interface axi_mem_slave_if;
  import axi_mem_slave_pkg::*;

  logic                      axi_aw_ready_o;
  logic                      axi_aw_valid_i;
  logic [AXI_ADDR_WIDTH-1:0] axi_aw_addr_i;
  logic [AXI_ID_WIDTH-1:0]   axi_aw_id_i;
  logic [7:0]                axi_aw_len_i;
  logic [2:0]                axi_aw_size_i;
  logic [1:0]                axi_aw_burst_i;

  logic                      axi_w_ready_o;
  logic                      axi_w_valid_i;
  logic [AXI_DATA_WIDTH-1:0] axi_w_data_i;
  logic [AXI_STRB_WIDTH-1:0] axi_w_strb_i;
  logic                      axi_w_last_i;

  logic                      axi_b_ready_i;
  logic                      axi_b_valid_o;
  logic [1:0]                axi_b_resp_o;
  logic [AXI_ID_WIDTH-1:0]   axi_b_id_o;
  logic [AXI_USER_WIDTH-1:0] axi_b_user_o;

  logic                      axi_ar_ready_o;
  logic                      axi_ar_valid_i;
  logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr_i;
  logic [AXI_ID_WIDTH-1:0]   axi_ar_id_i;
  logic [7:0]                axi_ar_len_i;
  logic [2:0]                axi_ar_size_i;
  logic [1:0]                axi_ar_burst_i;

  logic                      axi_r_ready_i;
  logic                      axi_r_valid_o;
  logic [AXI_DATA_WIDTH-1:0] axi_r_data_o;
  logic [1:0]                axi_r_resp_o;
  logic                      axi_r_last_o;
  logic [AXI_ID_WIDTH-1:0]   axi_r_id_o;
  logic [AXI_USER_WIDTH-1:0] axi_r_user_o;

  modport slave (
    output axi_aw_ready_o,
    input  axi_aw_valid_i, axi_aw_addr_i, axi_aw_id_i, axi_aw_len_i, axi_aw_size_i, axi_aw_burst_i,
    output axi_w_ready_o,
    input  axi_w_valid_i, axi_w_data_i, axi_w_strb_i, axi_w_last_i,
    input  axi_b_ready_i,
    output axi_b_valid_o, axi_b_resp_o, axi_b_id_o, axi_b_user_o,
    output axi_ar_ready_o,
    input  axi_ar_valid_i, axi_ar_addr_i, axi_ar_id_i, axi_ar_len_i, axi_ar_size_i, axi_ar_burst_i,
    input  axi_r_ready_i,
    output axi_r_valid_o, axi_r_data_o, axi_r_resp_o, axi_r_last_o, axi_r_id_o, axi_r_user_o
  );

  modport master (
    input  axi_aw_ready_o,
    output axi_aw_valid_i, axi_aw_addr_i, axi_aw_id_i, axi_aw_len_i, axi_aw_size_i, axi_aw_burst_i,
    input  axi_w_ready_o,
    output axi_w_valid_i, axi_w_data_i, axi_w_strb_i, axi_w_last_i,
    output axi_b_ready_i,
    input  axi_b_valid_o, axi_b_resp_o, axi_b_id_o, axi_b_user_o,
    input  axi_ar_ready_o,
    output axi_ar_valid_i, axi_ar_addr_i, axi_ar_id_i, axi_ar_len_i, axi_ar_size_i, axi_ar_burst_i,
    output axi_r_ready_i,
    input  axi_r_valid_o, axi_r_data_o, axi_r_resp_o, axi_r_last_o, axi_r_id_o, axi_r_user_o
  );

endinterface

// File: rtl/axi_mem_slave_ram.sv
// axi_slv_ram: MEM_WORDS x 64 storage, combinational read port and one
// byte-strobed synchronous write port. Contents are never reset.
module axi_slv_ram
  import axi_mem_slave_pkg::*;
#(
  parameter int MEM_WORDS = 4096
) (
  input  logic                         clock,
  input  logic [$clog2(MEM_WORDS)-1:0] rd_idx,
  output logic [AXI_DATA_WIDTH-1:0]    rd_data,
  input  logic                         we,
  input  logic [$clog2(MEM_WORDS)-1:0] wr_idx,
  input  logic [AXI_STRB_WIDTH-1:0]    wr_strb,
  input  logic [AXI_DATA_WIDTH-1:0]    wr_data
);

  logic [AXI_STRB_WIDTH-1:0][7:0] mem [MEM_WORDS];

  assign rd_data = mem[rd_idx];

  always_ff @(posedge clock) begin
    if (we) begin
      for (int b = 0; b < AXI_STRB_WIDTH; b++) begin
        if (wr_strb[b]) mem[wr_idx][b] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 memory responder: one outstanding read and one outstanding write over
// an internal word RAM. Define AXI_SLV_DECERR_EN to flag out-of-range beats.
module axi_mem_slave
  import axi_mem_slave_pkg::*;
#(
  parameter int          MEM_WORDS = 4096,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic           clock,
  input  logic           reset,
  axi_mem_slave_if.slave axi
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  // Without range checking the index simply wraps modulo MEM_WORDS.
  function automatic logic [IDX_W-1:0] word_idx(input logic [AXI_ADDR_WIDTH-1:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> 3);
  endfunction

`ifdef AXI_SLV_DECERR_EN
  function automatic logic addr_oob(input logic [AXI_ADDR_WIDTH-1:0] addr);
    return (addr < BASE_ADDR) || (addr >= BASE_ADDR + 64'(MEM_WORDS) * 64'd8);
  endfunction
`endif

  // ---------------- read channel ----------------
  rd_state_e                 rd_state, rd_state_nxt;
  ax_req_t                   ar_q;
  logic [7:0]                r_cnt;
  logic                      r_valid_q, r_last_q;
  logic [AXI_DATA_WIDTH-1:0] r_data_q, ram_rd_data, r_beat_data;
  logic [1:0]                r_resp_q, r_beat_resp;
  logic [AXI_ADDR_WIDTH-1:0] r_beat_addr;
  logic [IDX_W-1:0]          rd_idx;
  logic                      ar_hs, r_hs;

  assign axi.axi_ar_ready_o = (rd_state == R_IDLE);
  assign ar_hs              = axi.axi_ar_valid_i && axi.axi_ar_ready_o;
  assign r_hs               = r_valid_q && axi.axi_r_ready_i;
  // Address of the beat to be loaded into the R register at this edge.
  assign r_beat_addr        = ar_hs ? axi.axi_ar_addr_i : next_addr(ar_q.addr, ar_q.size, ar_q.burst);
  assign rd_idx             = word_idx(r_beat_addr);

`ifdef AXI_SLV_DECERR_EN
  logic r_oob;
  assign r_oob       = addr_oob(r_beat_addr);
  assign r_beat_data = r_oob ? '0 : ram_rd_data;
  assign r_beat_resp = r_oob ? AXI_RESP_DECERR : AXI_RESP_OKAY;
`else
  assign r_beat_data = ram_rd_data;
  assign r_beat_resp = AXI_RESP_OKAY;
`endif

  always_ff @(posedge clock) begin
    if (!reset) rd_state <= R_IDLE;
    else        rd_state <= rd_state_nxt;
  end

  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      R_IDLE:  if (ar_hs) rd_state_nxt = R_DATA;
      R_DATA:  if (r_hs && r_last_q) rd_state_nxt = R_IDLE;
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ar_q      <= '0;
      r_cnt     <= '0;
      r_valid_q <= 1'b0;
      r_last_q  <= 1'b0;
      r_data_q  <= '0;
      r_resp_q  <= AXI_RESP_OKAY;
    end else if (ar_hs) begin
      ar_q      <= '{addr: axi.axi_ar_addr_i, id: axi.axi_ar_id_i, len: axi.axi_ar_len_i,
                     size: clamp_size(axi.axi_ar_size_i), burst: axi.axi_ar_burst_i};
      r_cnt     <= '0;
      r_valid_q <= 1'b1;
      r_last_q  <= (axi.axi_ar_len_i == 8'd0);
      r_data_q  <= r_beat_data;
      r_resp_q  <= r_beat_resp;
    end else if (r_hs) begin
      if (r_last_q) begin
        r_valid_q <= 1'b0;
        r_last_q  <= 1'b0;
      end else begin
        ar_q.addr <= r_beat_addr;
        r_cnt     <= r_cnt + 8'd1;
        r_last_q  <= (r_cnt + 8'd1 == ar_q.len);
        r_data_q  <= r_beat_data;
        r_resp_q  <= r_beat_resp;
      end
    end
  end

  assign axi.axi_r_valid_o = r_valid_q;
  assign axi.axi_r_data_o  = r_data_q;
  assign axi.axi_r_resp_o  = r_resp_q;
  assign axi.axi_r_last_o  = r_last_q;
  assign axi.axi_r_id_o    = ar_q.id;
  assign axi.axi_r_user_o  = '0;

  // ---------------- write channel ----------------
  wr_state_e        wr_state, wr_state_nxt;
  ax_req_t          aw_q;
  logic [7:0]       w_cnt;
  logic             slv_err, dec_err;
  logic             aw_hs, w_hs, w_final, w_bad_last, w_oob, ram_we;
  logic [IDX_W-1:0] wr_idx;

  assign axi.axi_aw_ready_o = (wr_state == W_IDLE);
  assign axi.axi_w_ready_o  = (wr_state == W_DATA);
  assign axi.axi_b_valid_o  = (wr_state == W_RESP);
  assign aw_hs              = axi.axi_aw_valid_i && axi.axi_aw_ready_o;
  assign w_hs               = axi.axi_w_valid_i && axi.axi_w_ready_o;
  // The beat count, not w_last, closes the burst; a disagreeing w_last is an error.
  assign w_final            = (w_cnt == aw_q.len);
  assign w_bad_last         = w_final ? !axi.axi_w_last_i : axi.axi_w_last_i;
  assign wr_idx             = word_idx(aw_q.addr);

`ifdef AXI_SLV_DECERR_EN
  assign w_oob = addr_oob(aw_q.addr);
`else
  assign w_oob = 1'b0;
`endif
  assign ram_we = w_hs && !w_oob;

  always_ff @(posedge clock) begin
    if (!reset) wr_state <= W_IDLE;
    else        wr_state <= wr_state_nxt;
  end

  always_comb begin
    wr_state_nxt = wr_state;
    case (wr_state)
      W_IDLE:  if (aw_hs) wr_state_nxt = W_DATA;
      W_DATA:  if (w_hs && w_final) wr_state_nxt = W_RESP;
      W_RESP:  if (axi.axi_b_ready_i) wr_state_nxt = W_IDLE;
      default: wr_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      aw_q    <= '0;
      w_cnt   <= '0;
      slv_err <= 1'b0;
      dec_err <= 1'b0;
    end else if (aw_hs) begin
      aw_q    <= '{addr: axi.axi_aw_addr_i, id: axi.axi_aw_id_i, len: axi.axi_aw_len_i,
                   size: clamp_size(axi.axi_aw_size_i), burst: axi.axi_aw_burst_i};
      w_cnt   <= '0;
      slv_err <= 1'b0;
      dec_err <= 1'b0;
    end else if (w_hs) begin
      aw_q.addr <= next_addr(aw_q.addr, aw_q.size, aw_q.burst);
      w_cnt     <= w_cnt + 8'd1;
      slv_err   <= slv_err | w_bad_last;
      dec_err   <= dec_err | w_oob;
    end
  end

  assign axi.axi_b_resp_o = dec_err ? AXI_RESP_DECERR :
                            slv_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign axi.axi_b_id_o   = aw_q.id;
  assign axi.axi_b_user_o = '0;

  axi_slv_ram #(.MEM_WORDS(MEM_WORDS)) u_ram (
    .clock   (clock),
    .rd_idx  (rd_idx),
    .rd_data (ram_rd_data),
    .we      (ram_we),
    .wr_idx  (wr_idx),
    .wr_strb (axi.axi_w_strb_i),
    .wr_data (axi.axi_w_data_i)
  );

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave: inputs change 1ns after posedge, outputs
// are sampled at that same point, before any new stimulus is applied.
module tb_axi_mem_slave;
  import axi_mem_slave_pkg::*;

  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [63:0] TOP  = BASE + 64'h8000;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  logic [63:0] wd [16];
  logic [7:0]  ws [16];
  logic        wl [16];
  logic [63:0] rdata;
  logic [1:0]  rresp;

  axi_mem_slave_if bus();

  axi_mem_slave dut (.clock(clock), .reset(reset), .axi(bus));

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic idle_inputs();
    bus.axi_aw_valid_i = 0; bus.axi_aw_addr_i = '0; bus.axi_aw_id_i = '0;
    bus.axi_aw_len_i = '0; bus.axi_aw_size_i = 3'd3; bus.axi_aw_burst_i = AXI_BURST_INCR;
    bus.axi_w_valid_i = 0; bus.axi_w_data_i = '0; bus.axi_w_strb_i = '0; bus.axi_w_last_i = 0;
    bus.axi_b_ready_i = 0;
    bus.axi_ar_valid_i = 0; bus.axi_ar_addr_i = '0; bus.axi_ar_id_i = '0;
    bus.axi_ar_len_i = '0; bus.axi_ar_size_i = 3'd3; bus.axi_ar_burst_i = AXI_BURST_INCR;
    bus.axi_r_ready_i = 0;
  endtask

  task automatic set_beats(input int n, input logic [63:0] dbase);
    for (int i = 0; i < 16; i++) begin
      wd[i] = dbase + 64'(i); ws[i] = 8'hFF; wl[i] = (i == n - 1);
    end
  endtask

  // Fixed-timing write: AW then len+1 W beats; leaves the DUT expected in W_RESP.
  task automatic write_burst(input logic [63:0] addr, input logic [3:0] id, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
    bus.axi_aw_valid_i = 1; bus.axi_aw_addr_i = addr; bus.axi_aw_id_i = id;
    bus.axi_aw_len_i = len; bus.axi_aw_size_i = size; bus.axi_aw_burst_i = burst;
    tick();
    bus.axi_aw_valid_i = 0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.axi_w_valid_i = 1; bus.axi_w_data_i = wd[i]; bus.axi_w_strb_i = ws[i]; bus.axi_w_last_i = wl[i];
      tick();
    end
    bus.axi_w_valid_i = 0; bus.axi_w_last_i = 0;
  endtask

  task automatic b_accept();
    bus.axi_b_ready_i = 1; tick(); bus.axi_b_ready_i = 0;
  endtask

  task automatic ar_issue(input logic [63:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    bus.axi_ar_valid_i = 1; bus.axi_ar_addr_i = addr; bus.axi_ar_id_i = id;
    bus.axi_ar_len_i = len; bus.axi_ar_size_i = size; bus.axi_ar_burst_i = burst;
    tick();
    bus.axi_ar_valid_i = 0;
  endtask

  task automatic read1(input logic [63:0] addr, output logic [63:0] d, output logic [1:0] r);
    ar_issue(addr, 4'd0, 8'd0, 3'd3, AXI_BURST_INCR);
    d = bus.axi_r_data_o; r = bus.axi_r_resp_o;
    bus.axi_r_ready_i = 1; tick(); bus.axi_r_ready_i = 0;
  endtask

  task automatic test_reset();
    idle_inputs(); reset = 0; tick(); tick();
    vectors++; if ({bus.axi_ar_ready_o, bus.axi_aw_ready_o, bus.axi_w_ready_o, bus.axi_r_valid_o, bus.axi_b_valid_o, bus.axi_r_last_o} !== 6'b110000) begin
      miscompares++; $display("FAIL reset_ctrl: got %b want 110000", {bus.axi_ar_ready_o, bus.axi_aw_ready_o, bus.axi_w_ready_o, bus.axi_r_valid_o, bus.axi_b_valid_o, bus.axi_r_last_o}); end
    vectors++; if ({bus.axi_r_data_o, bus.axi_r_resp_o, bus.axi_r_id_o, bus.axi_b_resp_o, bus.axi_b_id_o} !== '0) begin
      miscompares++; $display("FAIL reset_data: r_data=%h r_resp=%b r_id=%h b_resp=%b b_id=%h want all 0", bus.axi_r_data_o, bus.axi_r_resp_o, bus.axi_r_id_o, bus.axi_b_resp_o, bus.axi_b_id_o); end
    reset = 1; tick();
  endtask

  task automatic test_single_read();
    set_beats(1, 64'hDEAD_BEEF_0123_4567);
    write_burst(BASE, 4'd9, 8'd0, 3'd3, AXI_BURST_INCR);
    vectors++; if ({bus.axi_b_valid_o, bus.axi_b_resp_o, bus.axi_b_id_o} !== {1'b1, 2'b00, 4'd9}) begin
      miscompares++; $display("FAIL single_b: got v=%b resp=%b id=%h want 1/00/9", bus.axi_b_valid_o, bus.axi_b_resp_o, bus.axi_b_id_o); end
    b_accept();
    ar_issue(BASE, 4'd5, 8'd0, 3'd3, AXI_BURST_INCR);
    vectors++; if ({bus.axi_r_valid_o, bus.axi_r_last_o, bus.axi_r_id_o, bus.axi_r_resp_o, bus.axi_ar_ready_o} !== {1'b1, 1'b1, 4'd5, 2'b00, 1'b0}) begin
      miscompares++; $display("FAIL single_r_ctrl: got v=%b last=%b id=%h resp=%b arr=%b want 1/1/5/00/0", bus.axi_r_valid_o, bus.axi_r_last_o, bus.axi_r_id_o, bus.axi_r_resp_o, bus.axi_ar_ready_o); end
    vectors++; if (bus.axi_r_data_o !== 64'hDEAD_BEEF_0123_4567) begin
      miscompares++; $display("FAIL single_r_data: got %h want deadbeef01234567", bus.axi_r_data_o); end
    bus.axi_r_ready_i = 1; tick(); bus.axi_r_ready_i = 0;
    vectors++; if ({bus.axi_r_valid_o, bus.axi_ar_ready_o} !== 2'b01) begin
      miscompares++; $display("FAIL single_r_done: got v=%b arr=%b want 0/1", bus.axi_r_valid_o, bus.axi_ar_ready_o); end
  endtask

  task automatic test_burst_stall();
    set_beats(4, 64'd1);
    write_burst(BASE + 64'h10, 4'd3, 8'd3, 3'd3, AXI_BURST_INCR);
    vectors++; if ({bus.axi_b_valid_o, bus.axi_b_resp_o, bus.axi_b_id_o, bus.axi_w_ready_o} !== {1'b1, 2'b00, 4'd3, 1'b0}) begin
      miscompares++; $display("FAIL burst_b: got v=%b resp=%b id=%h wr=%b want 1/00/3/0", bus.axi_b_valid_o, bus.axi_b_resp_o, bus.axi_b_id_o, bus.axi_w_ready_o); end
    b_accept();
    vectors++; if ({bus.axi_b_valid_o, bus.axi_aw_ready_o} !== 2'b01) begin
      miscompares++; $display("FAIL burst_b_done: got v=%b awr=%b want 0/1", bus.axi_b_valid_o, bus.axi_aw_ready_o); end
    ar_issue(BASE + 64'h10, 4'd7, 8'd3, 3'd3, AXI_BURST_INCR);
    bus.axi_r_ready_i = 1;
    for (int i = 0; i < 4; i++) begin
      vectors++; if ({bus.axi_r_valid_o, bus.axi_r_last_o, bus.axi_r_data_o} !== {1'b1, (i == 3), 64'(i + 1)}) begin
        miscompares++; $display("FAIL burst_beat%0d: got v=%b last=%b data=%h want 1/%0d/%0d", i, bus.axi_r_valid_o, bus.axi_r_last_o, bus.axi_r_data_o, (i == 3), i + 1); end
      if (i == 1) begin
        bus.axi_r_ready_i = 0;
        for (int s = 0; s < 3; s++) begin
          tick();
          vectors++; if ({bus.axi_r_valid_o, bus.axi_r_last_o, bus.axi_r_data_o} !== {1'b1, 1'b0, 64'd2}) begin
            miscompares++; $display("FAIL burst_stall%0d: got v=%b last=%b data=%h want 1/0/2", s, bus.axi_r_valid_o, bus.axi_r_last_o, bus.axi_r_data_o); end
        end
        bus.axi_r_ready_i = 1;
      end
      tick();
    end
    bus.axi_r_ready_i = 0;
    vectors++; if ({bus.axi_r_valid_o, bus.axi_ar_ready_o} !== 2'b01) begin
      miscompares++; $display("FAIL burst_r_done: got v=%b arr=%b want 0/1", bus.axi_r_valid_o, bus.axi_ar_ready_o); end
  endtask

  task automatic test_strobe();
    set_beats(1, 64'h1111_1111_1111_1111);
    write_burst(BASE + 64'h100, 4'd1, 8'd0, 3'd3, AXI_BURST_INCR); b_accept();
    wd[0] = 64'hAAAA_AAAA_BBBB_BBBB; ws[0] = 8'h0F;
    write_burst(BASE + 64'h100, 4'd1, 8'd0, 3'd3, AXI_BURST_INCR); b_accept();
    read1(BASE + 64'h100, rdata, rresp);
    vectors++; if (rdata !== 64'h1111_1111_BBBB_BBBB) begin
      miscompares++; $display("FAIL strobe: got %h want 11111111bbbbbbbb", rdata); end
  endtask

  task automatic test_wlast_err();
    set_beats(2, 64'h55);
    wd[1] = 64'h66; wl[0] = 1; wl[1] = 1;
    write_burst(BASE + 64'h200, 4'd4, 8'd1, 3'd3, AXI_BURST_INCR);
    vectors++; if ({bus.axi_b_valid_o, bus.axi_b_resp_o} !== {1'b1, AXI_RESP_SLVERR}) begin
      miscompares++; $display("FAIL wlast_b: got v=%b resp=%b want 1/10", bus.axi_b_valid_o, bus.axi_b_resp_o); end
    b_accept();
    read1(BASE + 64'h208, rdata, rresp);
    vectors++; if (rdata !== 64'h66) begin
      miscompares++; $display("FAIL wlast_beat1: got %h want 66", rdata); end
  endtask

  task automatic test_fixed_narrow();
    set_beats(2, 64'd7);
    write_burst(BASE + 64'h600, 4'd2, 8'd1, 3'd3, AXI_BURST_FIXED); b_accept();
    ar_issue(BASE + 64'h600, 4'd2, 8'd1, 3'd3, AXI_BURST_FIXED);
    bus.axi_r_ready_i = 1;
    for (int i = 0; i < 2; i++) begin
      vectors++; if ({bus.axi_r_last_o, bus.axi_r_data_o} !== {(i == 1), 64'd8}) begin
        miscompares++; $display("FAIL fixed_beat%0d: got last=%b data=%h want %0d/8", i, bus.axi_r_last_o, bus.axi_r_data_o, (i == 1)); end
      tick();
    end
    bus.axi_r_ready_i = 0;
    // size=2: both beats land in the same 64-bit word, different halves.
    set_beats(2, 64'h0);
    wd[0] = 64'h0000_0000_1234_5678; ws[0] = 8'h0F;
    wd[1] = 64'h9ABC_DEF0_0000_0000; ws[1] = 8'hF0;
    write_burst(BASE + 64'h700, 4'd2, 8'd1, 3'd2, AXI_BURST_INCR); b_accept();
    read1(BASE + 64'h700, rdata, rresp);
    vectors++; if (rdata !== 64'h9ABC_DEF0_1234_5678) begin
      miscompares++; $display("FAIL narrow: got %h want 9abcdef012345678", rdata); end
  endtask

  task automatic test_rw_collision();
    set_beats(1, 64'h0123);
    write_burst(BASE + 64'h800, 4'd0, 8'd0, 3'd3, AXI_BURST_INCR); b_accept();
    bus.axi_aw_valid_i = 1; bus.axi_aw_addr_i = BASE + 64'h800; bus.axi_aw_len_i = 8'd0;
    tick();
    bus.axi_aw_valid_i = 0;
    bus.axi_w_valid_i = 1; bus.axi_w_data_i = 64'h4567; bus.axi_w_strb_i = 8'hFF; bus.axi_w_last_i = 1;
    bus.axi_ar_valid_i = 1; bus.axi_ar_addr_i = BASE + 64'h800; bus.axi_ar_len_i = 8'd0;
    tick();
    bus.axi_w_valid_i = 0; bus.axi_w_last_i = 0; bus.axi_ar_valid_i = 0;
    vectors++; if ({bus.axi_r_valid_o, bus.axi_r_data_o, bus.axi_b_valid_o} !== {1'b1, 64'h0123, 1'b1}) begin
      miscompares++; $display("FAIL collide_old: got rv=%b data=%h bv=%b want 1/0123/1", bus.axi_r_valid_o, bus.axi_r_data_o, bus.axi_b_valid_o); end
    bus.axi_r_ready_i = 1; bus.axi_b_ready_i = 1; tick();
    bus.axi_r_ready_i = 0; bus.axi_b_ready_i = 0;
    read1(BASE + 64'h800, rdata, rresp);
    vectors++; if (rdata !== 64'h4567) begin
      miscompares++; $display("FAIL collide_new: got %h want 4567", rdata); end
  endtask

  task automatic test_range();
    read1(TOP, rdata, rresp);
`ifdef AXI_SLV_DECERR_EN
    vectors++; if ({rresp, rdata} !== {AXI_RESP_DECERR, 64'h0}) begin
      miscompares++; $display("FAIL oob_read: got resp=%b data=%h want 11/0", rresp, rdata); end
`else
    vectors++; if ({rresp, rdata} !== {AXI_RESP_OKAY, 64'hDEAD_BEEF_0123_4567}) begin
      miscompares++; $display("FAIL oob_read: got resp=%b data=%h want 00/deadbeef01234567", rresp, rdata); end
`endif
    // Last in-range word then first out-of-range word, w_last early on beat 0.
    set_beats(2, 64'h99);
    wl[0] = 1; wl[1] = 1;
    write_burst(TOP - 64'h8, 4'd6, 8'd1, 3'd3, AXI_BURST_INCR);
`ifdef AXI_SLV_DECERR_EN
    vectors++; if ({bus.axi_b_valid_o, bus.axi_b_resp_o} !== {1'b1, AXI_RESP_DECERR}) begin
      miscompares++; $display("FAIL oob_write_b: got v=%b resp=%b want 1/11", bus.axi_b_valid_o, bus.axi_b_resp_o); end
`else
    vectors++; if ({bus.axi_b_valid_o, bus.axi_b_resp_o} !== {1'b1, AXI_RESP_SLVERR}) begin
      miscompares++; $display("FAIL oob_write_b: got v=%b resp=%b want 1/10", bus.axi_b_valid_o, bus.axi_b_resp_o); end
`endif
    b_accept();
    read1(TOP - 64'h8, rdata, rresp);
    vectors++; if ({rresp, rdata} !== {AXI_RESP_OKAY, 64'h99}) begin
      miscompares++; $display("FAIL top_word: got resp=%b data=%h want 00/99", rresp, rdata); end
  endtask

  task automatic test_reset_mid_burst();
    set_beats(8, 64'h100);
    write_burst(BASE + 64'h400, 4'd0, 8'd7, 3'd3, AXI_BURST_INCR); b_accept();
    ar_issue(BASE + 64'h400, 4'd8, 8'd7, 3'd3, AXI_BURST_INCR);
    bus.axi_r_ready_i = 1;
    tick(); tick();
    vectors++; if ({bus.axi_r_valid_o, bus.axi_r_data_o} !== {1'b1, 64'h102}) begin
      miscompares++; $display("FAIL mid_beat2: got v=%b data=%h want 1/102", bus.axi_r_valid_o, bus.axi_r_data_o); end
    reset = 0; bus.axi_r_ready_i = 0;
    tick();
    vectors++; if ({bus.axi_r_valid_o, bus.axi_ar_ready_o, bus.axi_aw_ready_o, bus.axi_b_valid_o} !== 4'b0110) begin
      miscompares++; $display("FAIL mid_reset: got rv=%b arr=%b awr=%b bv=%b want 0/1/1/0", bus.axi_r_valid_o, bus.axi_ar_ready_o, bus.axi_aw_ready_o, bus.axi_b_valid_o); end
    reset = 1; tick();
    ar_issue(BASE + 64'h408, 4'd2, 8'd0, 3'd3, AXI_BURST_INCR);
    vectors++; if ({bus.axi_r_valid_o, bus.axi_r_last_o, bus.axi_r_id_o, bus.axi_r_data_o} !== {1'b1, 1'b1, 4'd2, 64'h101}) begin
      miscompares++; $display("FAIL mid_after: got v=%b last=%b id=%h data=%h want 1/1/2/101", bus.axi_r_valid_o, bus.axi_r_last_o, bus.axi_r_id_o, bus.axi_r_data_o); end
    bus.axi_r_ready_i = 1; tick(); bus.axi_r_ready_i = 0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_burst_stall();
    test_strobe();
    test_wlast_err();
    test_fixed_narrow();
    test_rw_collision();
    test_range();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
